// File: rtl/tcm_arb_pkg.sv
// Shared types and widths for the TCM second-port arbiter.
package tcm_arb_pkg;

  localparam int TCM_ADDR_W = 9;
  localparam int TCM_DATA_W = 32;
  localparam int TCM_BE_W   = 4;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // One entry per cycle in the read-return pipe.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/tcm_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, owner} alongside the RAM read latency.
module tcm_rd_tag_pipe
  import tcm_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       clr_n_i,
  input  logic [1:0] tag_i,
  output logic [1:0] tag_o
);

  rd_tag_t pipe_q [RD_LATENCY];

  // Shift tags one stage per cycle; clear drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rd_tag_t'(tag_i);
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/tcm_port_arbiter.sv
// Round-robin arbiter sharing TCM port s2 between two Avalon-MM masters,
// with per-master lock for atomic read-modify-write and read ownership tags.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int ADDR_W     = TCM_ADDR_W,
  parameter int DATA_W     = TCM_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic                m0_read_i,
  input  logic                m0_write_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_i,
  input  logic                m0_lock_i,
  output logic                m0_waitrequest_o,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdatavalid_o,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_i,
  input  logic                m1_lock_i,
  output logic                m1_waitrequest_o,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdatavalid_o,
  output logic [ADDR_W-1:0]   ram_address_o,
  output logic                ram_chipselect_o,
  output logic                ram_write_o,
  output logic [DATA_W-1:0]   ram_writedata_o,
  output logic [DATA_W/8-1:0] ram_byteenable_o,
  input  logic [DATA_W-1:0]   ram_readdata_i
);

  localparam int BE_W = DATA_W / 8;

  logic    req0, req1, gnt0, gnt1;
  owner_e  last_q, last_d;
  logic    lock_vld_q, lock_vld_d;
  owner_e  lock_own_q, lock_own_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  rd_tag_t tag_push, tag_out;

  assign req0 = m0_read_i | m0_write_i;
  assign req1 = m1_read_i | m1_write_i;

  // Grant: lock owner has exclusive access; otherwise round-robin on contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n_i) begin
      if (lock_vld_q) begin
        gnt0 = req0 && (lock_own_q == OWN_M0);
        gnt1 = req1 && (lock_own_q == OWN_M1);
      end else if (req0 && req1) begin
        gnt0 = (last_q == OWN_M1);
        gnt1 = (last_q == OWN_M0);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign m0_waitrequest_o = ~gnt0;
  assign m1_waitrequest_o = ~gnt1;

  // Command mux: granted master drives the RAM, otherwise hold the last command.
  always_comb begin
    ram_address_o    = addr_q;
    ram_writedata_o  = wdata_q;
    ram_byteenable_o = be_q;
    ram_chipselect_o = 1'b0;
    ram_write_o      = 1'b0;
    if (gnt0) begin
      ram_address_o    = m0_address_i;
      ram_writedata_o  = m0_writedata_i;
      ram_byteenable_o = m0_byteenable_i;
      ram_chipselect_o = 1'b1;
      ram_write_o      = m0_write_i;
    end else if (gnt1) begin
      ram_address_o    = m1_address_i;
      ram_writedata_o  = m1_writedata_i;
      ram_byteenable_o = m1_byteenable_i;
      ram_chipselect_o = 1'b1;
      ram_write_o      = m1_write_i;
    end
  end

  // Next arbitration state: every accepted transfer sets last grant and lock.
  always_comb begin
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (gnt0) begin
      last_d     = OWN_M0;
      lock_vld_d = m0_lock_i;
      lock_own_d = OWN_M0;
    end else if (gnt1) begin
      last_d     = OWN_M1;
      lock_vld_d = m1_lock_i;
      lock_own_d = OWN_M1;
    end
  end

  // Arbitration state and held RAM command; last_grant=M1 so M0 wins first contention.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_q     <= OWN_M1;
      lock_vld_q <= 1'b0;
      lock_own_q <= OWN_M0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      addr_q     <= ram_address_o;
      wdata_q    <= ram_writedata_o;
      be_q       <= ram_byteenable_o;
    end
  end

  // A read carries a tag only when it is not overridden by a simultaneous write.
  assign tag_push.valid = (gnt0 & m0_read_i & ~m0_write_i) | (gnt1 & m1_read_i & ~m1_write_i);
  assign tag_push.owner = gnt1 ? OWN_M1 : OWN_M0;

  tcm_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .clk_i   (clk_i),
    .clr_n_i (reset_n_i),
    .tag_i   (tag_push),
    .tag_o   (tag_out)
  );

  assign m0_readdatavalid_o = reset_n_i & tag_out.valid & (tag_out.owner == OWN_M0);
  assign m1_readdatavalid_o = reset_n_i & tag_out.valid & (tag_out.owner == OWN_M1);
  assign m0_readdata_o      = ram_readdata_i;
  assign m1_readdata_o      = ram_readdata_i;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: two builds (latency 1 and 3) share the same
// master stimulus; a transaction-level model predicts grants and responses.
module tb_tcm_port_arbiter;
  import tcm_arb_pkg::*;

  localparam int AW = 9, DW = 32, BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [AW-1:0] m0_address, m1_address;
  logic m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable;

  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, ram_writedata, ram_readdata;
  logic [AW-1:0] ram_address;
  logic ram_chipselect, ram_write;
  logic [BW-1:0] ram_byteenable;

  logic t3_m0_waitrequest, t3_m1_waitrequest, t3_m0_readdatavalid, t3_m1_readdatavalid;
  logic [DW-1:0] t3_m0_readdata, t3_m1_readdata, t3_ram_writedata, t3_ram_readdata;
  logic [AW-1:0] t3_ram_address;
  logic t3_ram_chipselect, t3_ram_write;
  logic [BW-1:0] t3_ram_byteenable;

  tcm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_address_i(m0_address), .m0_read_i(m0_read), .m0_write_i(m0_write),
    .m0_writedata_i(m0_writedata), .m0_byteenable_i(m0_byteenable), .m0_lock_i(m0_lock),
    .m0_waitrequest_o(m0_waitrequest), .m0_readdata_o(m0_readdata), .m0_readdatavalid_o(m0_readdatavalid),
    .m1_address_i(m1_address), .m1_read_i(m1_read), .m1_write_i(m1_write),
    .m1_writedata_i(m1_writedata), .m1_byteenable_i(m1_byteenable), .m1_lock_i(m1_lock),
    .m1_waitrequest_o(m1_waitrequest), .m1_readdata_o(m1_readdata), .m1_readdatavalid_o(m1_readdatavalid),
    .ram_address_o(ram_address), .ram_chipselect_o(ram_chipselect), .ram_write_o(ram_write),
    .ram_writedata_o(ram_writedata), .ram_byteenable_o(ram_byteenable), .ram_readdata_i(ram_readdata)
  );

  tcm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
    .clk_i(clk), .reset_n_i(rst_n),
    .m0_address_i(m0_address), .m0_read_i(m0_read), .m0_write_i(m0_write),
    .m0_writedata_i(m0_writedata), .m0_byteenable_i(m0_byteenable), .m0_lock_i(m0_lock),
    .m0_waitrequest_o(t3_m0_waitrequest), .m0_readdata_o(t3_m0_readdata), .m0_readdatavalid_o(t3_m0_readdatavalid),
    .m1_address_i(m1_address), .m1_read_i(m1_read), .m1_write_i(m1_write),
    .m1_writedata_i(m1_writedata), .m1_byteenable_i(m1_byteenable), .m1_lock_i(m1_lock),
    .m1_waitrequest_o(t3_m1_waitrequest), .m1_readdata_o(t3_m1_readdata), .m1_readdatavalid_o(t3_m1_readdatavalid),
    .ram_address_o(t3_ram_address), .ram_chipselect_o(t3_ram_chipselect), .ram_write_o(t3_ram_write),
    .ram_writedata_o(t3_ram_writedata), .ram_byteenable_o(t3_ram_byteenable), .ram_readdata_i(t3_ram_readdata)
  );

  // ---------------- RAM behind the latency-1 build ----------------
  function automatic logic [DW-1:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] rp  [0:2];
  logic mem_ok = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      mem_ok <= 1'b1;
    end else if (ram_chipselect && ram_write) begin
      for (int b = 0; b < BW; b++)
        if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
    rp[0] <= mem[ram_address];
    rp[1] <= rp[0];
    rp[2] <= rp[1];
  end
  assign ram_readdata    = rp[0];
  assign t3_ram_readdata = rp[2];

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic rd; logic wr; logic lk;
    logic [AW-1:0] a; logic [DW-1:0] d; logic [BW-1:0] be;
  } cmd_t;
  typedef struct packed { int due; int m; logic [DW-1:0] d; } rsp_t;

  cmd_t c0[$], c1[$];
  rsp_t q1[$], q3[$];
  logic [DW-1:0] ref_mem [0:511];
  int cyc = 0, m_last = 1, m_lock = -1, g = -1;
  bit m_had = 0;
  logic [AW-1:0] h_a; logic [DW-1:0] h_d; logic [BW-1:0] h_be;
  logic [7:0] exp_v;
  logic [AW+DW+BW-1:0] exp_cmd;
  bit chk_cmd, rd1_due, rd3_due;
  logic [DW-1:0] exp_d1, exp_d3;
  int ntests = 0, nfail = 0, n_xfer = 0, acc0 = -1, acc1 = -1;

  function automatic cmd_t mk(logic rd, logic wr, logic lk, logic [AW-1:0] a,
                              logic [DW-1:0] d, logic [BW-1:0] be);
    return {rd, wr, lk, a, d, be};
  endfunction

  function automatic bit busy();
    return (c0.size() + c1.size() + q1.size() + q3.size()) != 0;
  endfunction

  function automatic logic [7:0] obs_v();
    return {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_write,
            m0_readdatavalid, m1_readdatavalid, t3_m0_readdatavalid, t3_m1_readdatavalid};
  endfunction

  task automatic drive();
    cmd_t h0, h1;
    h0 = (c0.size() != 0) ? c0[0] : '0;
    h1 = (c1.size() != 0) ? c1[0] : '0;
    m0_read = h0.rd; m0_write = h0.wr; m0_lock = h0.lk;
    m0_address = h0.a; m0_writedata = h0.d; m0_byteenable = h0.be;
    m1_read = h1.rd; m1_write = h1.wr; m1_lock = h1.lk;
    m1_address = h1.a; m1_writedata = h1.d; m1_byteenable = h1.be;
  endtask

  // Predict this cycle's outputs from the heads of both command queues.
  task automatic eval();
    cmd_t h0, h1;
    bit r0, r1;
    h0 = (c0.size() != 0) ? c0[0] : '0;
    h1 = (c1.size() != 0) ? c1[0] : '0;
    r0 = h0.rd | h0.wr;
    r1 = h1.rd | h1.wr;
    g = -1;
    if (rst_n) begin
      if (m_lock >= 0)   g = ((m_lock == 0 && r0) || (m_lock == 1 && r1)) ? m_lock : -1;
      else if (r0 && r1) g = 1 - m_last;
      else if (r0)       g = 0;
      else if (r1)       g = 1;
    end
    rd1_due = rst_n && q1.size() != 0 && q1[0].due == cyc;
    rd3_due = rst_n && q3.size() != 0 && q3[0].due == cyc;
    exp_v = {g != 0, g != 1, g >= 0, (g == 0 && h0.wr) || (g == 1 && h1.wr),
             rd1_due && q1[0].m == 0, rd1_due && q1[0].m == 1,
             rd3_due && q3[0].m == 0, rd3_due && q3[0].m == 1};
    exp_d1 = rd1_due ? q1[0].d : '0;
    exp_d3 = rd3_due ? q3[0].d : '0;
    chk_cmd = rst_n && (g >= 0 || m_had);
    exp_cmd = (g == 0) ? {h0.a, h0.d, h0.be} : (g == 1) ? {h1.a, h1.d, h1.be} : {h_a, h_d, h_be};
  endtask

  // Commit the clock edge to the model (called just after posedge).
  task automatic advance();
    cmd_t h;
    if (q1.size() != 0 && q1[0].due == cyc) void'(q1.pop_front());
    if (q3.size() != 0 && q3[0].due == cyc) void'(q3.pop_front());
    if (c0.size() != 0 && !(c0[0].rd || c0[0].wr)) void'(c0.pop_front());
    if (c1.size() != 0 && !(c1[0].rd || c1[0].wr)) void'(c1.pop_front());
    if (!rst_n) begin
      m_last = 1; m_lock = -1; m_had = 0;
      q1.delete(); q3.delete();
    end else if (g >= 0) begin
      h = (g == 0) ? c0[0] : c1[0];
      m_last = g;
      m_lock = h.lk ? g : -1;
      {h_a, h_d, h_be} = {h.a, h.d, h.be};
      m_had = 1;
      n_xfer++;
      if (h.wr) begin
        for (int b = 0; b < BW; b++) if (h.be[b]) ref_mem[h.a][8*b +: 8] = h.d[8*b +: 8];
      end else if (h.rd) begin
        q1.push_back('{cyc + 1, g, ref_mem[h.a]});
        q3.push_back('{cyc + 3, g, ref_mem[h.a]});
      end
      if (g == 0) begin void'(c0.pop_front()); acc0 = cyc; end
      else        begin void'(c1.pop_front()); acc1 = cyc; end
    end
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    c0.push_back(mk(1, 0, 0, 9'h010, 0, 4'hF));
    c1.push_back(mk(0, 1, 1, 9'h020, 32'h1234, 4'hF));
    for (int i = 0; i < 3; i++) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL reset flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      @(posedge clk); advance(); #1;
    end
    c0.delete(); c1.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_simul_read();
    int lim = 0, t0 = cyc;
    c0.push_back(mk(1, 0, 0, 9'h010, 0, 4'hF));
    c1.push_back(mk(1, 0, 0, 9'h020, 0, 4'hF));
    while (busy() && lim < 50) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL simul_read flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      if (chk_cmd) begin ntests++; if ({ram_address, ram_writedata, ram_byteenable} !== exp_cmd) begin nfail++; $display("FAIL simul_read cmd cyc=%0d got=%h want=%h", cyc, {ram_address, ram_writedata, ram_byteenable}, exp_cmd); end end
      if (rd1_due) begin ntests++; if ({m0_readdata, m1_readdata} !== {exp_d1, exp_d1}) begin nfail++; $display("FAIL simul_read rdata cyc=%0d got=%h want=%h", cyc, m0_readdata, exp_d1); end end
      if (rd3_due) begin ntests++; if ({t3_m0_readdata, t3_m1_readdata} !== {exp_d3, exp_d3}) begin nfail++; $display("FAIL simul_read rdata3 cyc=%0d got=%h want=%h", cyc, t3_m0_readdata, exp_d3); end end
      @(posedge clk); advance(); #1; lim++;
    end
    ntests++; if (busy()) begin nfail++; $display("FAIL simul_read timeout got=busy want=idle"); end
    ntests++; if (acc0 != t0 || acc1 != t0 + 1) begin nfail++; $display("FAIL simul_read order got m0@%0d m1@%0d want m0@%0d m1@%0d", acc0, acc1, t0, t0 + 1); end
  endtask

  task automatic test_back_to_back();
    int lim = 0, t0 = cyc, x0 = n_xfer, bad = 0;
    logic [DW-1:0] orig, d0;
    orig = ref_mem[9'h040];
    d0 = $urandom;
    for (int i = 0; i < 8; i++) begin
      c0.push_back(mk(0, 1, 0, 9'(9'h040 + i), (i == 0) ? d0 : $urandom, (i == 0) ? 4'b0011 : 4'($urandom_range(1, 15))));
      c1.push_back(mk(0, 1, 0, 9'(9'h080 + i), $urandom, 4'($urandom_range(1, 15))));
    end
    while (busy() && lim < 100) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL b2b flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      if (chk_cmd) begin ntests++; if ({ram_address, ram_writedata, ram_byteenable} !== exp_cmd) begin nfail++; $display("FAIL b2b cmd cyc=%0d got=%h want=%h", cyc, {ram_address, ram_writedata, ram_byteenable}, exp_cmd); end end
      @(posedge clk); advance(); #1; lim++;
    end
    ntests++; if (busy()) begin nfail++; $display("FAIL b2b timeout got=busy want=idle"); end
    ntests++; if (n_xfer - x0 != 16 || lim != 16) begin nfail++; $display("FAIL b2b throughput got %0d xfers in %0d cycles want 16 in 16", n_xfer - x0, lim); end
    ntests++; if (acc0 + acc1 != 2 * t0 + 29) begin nfail++; $display("FAIL b2b last_grants got m0@%0d m1@%0d want t0+14,t0+15 (t0=%0d)", acc0, acc1, t0); end
    ntests++; if (mem[9'h040] !== {orig[31:16], d0[15:0]}) begin nfail++; $display("FAIL b2b be0011 got=%h want=%h", mem[9'h040], {orig[31:16], d0[15:0]}); end
    for (int i = 0; i < 8; i++) begin
      if (mem[9'h040 + i] !== ref_mem[9'h040 + i]) bad++;
      if (mem[9'h080 + i] !== ref_mem[9'h080 + i]) bad++;
    end
    ntests++; if (bad != 0) begin nfail++; $display("FAIL b2b ram_contents got %0d bad words want 0", bad); end
  endtask

  task automatic test_lock();
    int lim = 0, t0 = cyc;
    c1.push_back(mk(0, 1, 1, 9'h1FF, 32'hCAFE0001, 4'hF));
    for (int i = 0; i < 3; i++) c1.push_back('0);
    c1.push_back(mk(0, 1, 0, 9'h1FE, 32'hCAFE0002, 4'hF));
    c0.push_back('0);
    c0.push_back(mk(1, 0, 0, 9'h1FF, 0, 4'hF));
    while (busy() && lim < 50) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL lock flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      if (chk_cmd) begin ntests++; if ({ram_address, ram_writedata, ram_byteenable} !== exp_cmd) begin nfail++; $display("FAIL lock cmd cyc=%0d got=%h want=%h", cyc, {ram_address, ram_writedata, ram_byteenable}, exp_cmd); end end
      if (rd1_due) begin ntests++; if (m0_readdata !== exp_d1) begin nfail++; $display("FAIL lock rdata cyc=%0d got=%h want=%h", cyc, m0_readdata, exp_d1); end end
      @(posedge clk); advance(); #1; lim++;
    end
    ntests++; if (busy()) begin nfail++; $display("FAIL lock timeout got=busy want=idle"); end
    ntests++; if (acc1 != t0 + 4 || acc0 != t0 + 5) begin nfail++; $display("FAIL lock release got m1@%0d m0@%0d want m1@%0d m0@%0d", acc1, acc0, t0 + 4, t0 + 5); end
  endtask

  task automatic test_rw_both();
    int lim = 0;
    c0.push_back(mk(1, 1, 0, 9'h005, 32'hDEAD_BEEF, 4'hF));
    while (busy() && lim < 20) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL rw_both flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      @(posedge clk); advance(); #1; lim++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ntests++; if ({m0_readdatavalid, t3_m0_readdatavalid} !== 2'b00) begin nfail++; $display("FAIL rw_both rdv got=%b want=00", {m0_readdatavalid, t3_m0_readdatavalid}); end
      @(posedge clk); advance(); #1;
    end
    ntests++; if (mem[9'h005] !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL rw_both ram got=%h want=deadbeef", mem[9'h005]); end
  endtask

  task automatic test_reset_midread();
    int seen = 0;
    c0.push_back(mk(1, 0, 0, 9'h010, 0, 4'hF));
    for (int i = 0; i < 8; i++) begin
      if (i == 1) rst_n = 1'b0;
      if (i == 2) rst_n = 1'b1;
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL reset_mid flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      seen += m0_readdatavalid + m1_readdatavalid + t3_m0_readdatavalid + t3_m1_readdatavalid;
      @(posedge clk); advance(); #1;
    end
    ntests++; if (seen != 0) begin nfail++; $display("FAIL reset_mid stale_rdv got=%0d want=0", seen); end
  endtask

  task automatic test_lat3();
    int lim = 0, first;
    int own_q[$];
    first = 1 - m_last;
    for (int i = 0; i < 4; i++) begin
      c0.push_back(mk(1, 0, 0, 9'(9'h100 + 2 * i), 0, 4'hF));
      c1.push_back(mk(1, 0, 0, 9'(9'h101 + 2 * i), 0, 4'hF));
    end
    while (busy() && lim < 60) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL lat3 flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      if (rd3_due) begin ntests++; if (t3_m0_readdata !== exp_d3) begin nfail++; $display("FAIL lat3 rdata3 cyc=%0d got=%h want=%h", cyc, t3_m0_readdata, exp_d3); end end
      if (t3_m0_readdatavalid) own_q.push_back(0);
      if (t3_m1_readdatavalid) own_q.push_back(1);
      @(posedge clk); advance(); #1; lim++;
    end
    ntests++; if (busy()) begin nfail++; $display("FAIL lat3 timeout got=busy want=idle"); end
    ntests++; if (own_q.size() != 8) begin nfail++; $display("FAIL lat3 count got=%0d want=8", own_q.size()); end
    for (int k = 0; k < own_q.size(); k++) begin
      ntests++; if (own_q[k] != (first ^ (k & 1))) begin nfail++; $display("FAIL lat3 owner[%0d] got=%0d want=%0d", k, own_q[k], first ^ (k & 1)); end
    end
  endtask

  task automatic test_random();
    int lim = 0, r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 5);
      c0.push_back(mk(r == 1 || r == 2 || r == 5, r >= 3, $urandom_range(0, 5) == 0,
                      9'($urandom_range(0, 63)), $urandom, 4'($urandom_range(1, 15))));
      r = $urandom_range(0, 5);
      c1.push_back(mk(r == 1 || r == 2 || r == 5, r >= 3, $urandom_range(0, 5) == 0,
                      9'($urandom_range(0, 63)), $urandom, 4'($urandom_range(1, 15))));
    end
    c0.push_back(mk(1, 0, 0, 9'h000, 0, 4'hF));
    c1.push_back(mk(1, 0, 0, 9'h001, 0, 4'hF));
    while (busy() && lim < 600) begin
      drive(); @(negedge clk); eval();
      ntests++; if (obs_v() !== exp_v) begin nfail++; $display("FAIL random flags cyc=%0d got=%b want=%b", cyc, obs_v(), exp_v); end
      if (chk_cmd) begin ntests++; if ({ram_address, ram_writedata, ram_byteenable} !== exp_cmd) begin nfail++; $display("FAIL random cmd cyc=%0d got=%h want=%h", cyc, {ram_address, ram_writedata, ram_byteenable}, exp_cmd); end end
      if (rd1_due) begin ntests++; if ({m0_readdata, m1_readdata} !== {exp_d1, exp_d1}) begin nfail++; $display("FAIL random rdata cyc=%0d got=%h want=%h", cyc, m0_readdata, exp_d1); end end
      if (rd3_due) begin ntests++; if ({t3_m0_readdata, t3_m1_readdata} !== {exp_d3, exp_d3}) begin nfail++; $display("FAIL random rdata3 cyc=%0d got=%h want=%h", cyc, t3_m0_readdata, exp_d3); end end
      @(posedge clk); advance(); #1; lim++;
    end
    ntests++; if (busy()) begin nfail++; $display("FAIL random timeout got=busy want=idle"); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_simul_read();
    test_back_to_back();
    test_lock();
    test_rw_both();
    test_reset_midread();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Round-robin arbiter that shares the second port of the dual-port tightly-coupled memory between two Avalon-MM masters (the password-compare engine and the UART/DMA loader). Sits between the two masters and the TCM's s2 port; the Nios II keeps exclusive use of s1. Issues at most one transfer per cycle, tracks read ownership through the fixed RAM read latency, and supports a per-master lock for atomic read-modify-write.

## Interface
- ADDR_W, 9, word address width of the TCM port
- DATA_W, 32, data width; byteenable width is DATA_W/8
- RD_LATENCY, 1, cycles from accepted read to valid ram_readdata (legal range 1–4)

- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_lock / m1_lock  in  1  hold grant after this transfer
- m0_waitrequest / m1_waitrequest  out  1  transfer not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, qualified by readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- ram_address  out  ADDR_W  to TCM s2 address
- ram_chipselect  out  1  to TCM s2 chipselect
- ram_write  out  1  to TCM s2 write
- ram_writedata  out  DATA_W  to TCM s2 writedata
- ram_byteenable  out  DATA_W/8  to TCM s2 byteenable
- ram_readdata  in  DATA_W  from TCM s2 readdata

## Operation
- Request: mX_req = mX_read | mX_write. Read and write together: write wins, read dropped.
- Grant (combinational): if lock_owner valid, only lock_owner may be granted; else single requester wins; both requesting → master ≠ last_grant wins.
- Granted master: waitrequest=0, its command drives ram_*, ram_chipselect=1, ram_write=mX_write. Non-granted requester: waitrequest=1. Idle master: waitrequest=1 (Avalon-legal, no request pending).
- No request or lock owner idle: ram_chipselect=0, ram_write=0, ram_address/writedata/byteenable hold last granted values.
- Registers on each accepted transfer: last_grant ← X; lock_owner ← X if mX_lock=1, else cleared. Lock owner may idle any number of cycles; other master stalls until owner issues a transfer with lock=0.
- Read tag pipeline: RD_LATENCY-deep shift of {valid, owner}; accepted read pushes {1,X}, otherwise {0,-}. Tag output drives mX_readdatavalid for owner; mX_readdata = ram_readdata for both masters unconditionally.
- Writes produce no response.

## Timing
- Reset (reset_n=0 at clk edge): last_grant=1 (m0 wins first contention), lock_owner cleared, tag pipe cleared. While reset_n=0: both waitrequest=1, ram_chipselect=0, ram_write=0, readdatavalid=0.
- Reset mid-read: in-flight tags discarded; no readdatavalid returns after reset.
- Throughput: one transfer per cycle, back-to-back across masters with zero bubbles.
- Read latency seen by master: RD_LATENCY cycles after acceptance edge; readdatavalid high exactly one cycle per accepted read, in issue order.
- Contention with both requesting every cycle: grants alternate m0, m1, m0, ….
- ram_* outputs combinational from grant; no cycle added on command path.

## Structure
- Package tcm_arb_pkg: TCM_ADDR_W=9, TCM_DATA_W=32, TCM_BE_W=4, owner enum {OWN_M0, OWN_M1}, tag struct {valid, owner}.
- Sub-module tcm_rd_tag_pipe: parameterised RD_LATENCY shift register of tags with synchronous active-low clear.

## Test plan
- After reset both masters read addr 0x010/0x020 same cycle → m0 accepted cycle 0, m1 cycle 1; m0_readdatavalid cycle 1, m1_readdatavalid cycle 2, correct data each.
- Both stream 8 writes continuously → grants strictly alternate, 16 RAM writes in 16 cycles, ram contents match per byteenable (e.g. be=4'b0011 writes only low 16 bits).
- m1 write with lock=1 to 0x1FF, idles 3 cycles while m0 requests → m0 waitrequest=1 throughout until m1 write with lock=0; m0 granted next cycle.
- m0 asserts read and write together at 0x005 → RAM write issued, no readdatavalid.
- reset_n low one cycle after accepted read → no readdatavalid ever returns; outputs at reset values.
- RD_LATENCY=3 build, alternating reads → valid tags delayed exactly 3 cycles, owners preserved in order.
